// File: rtl/barcode_scan_ctrl.sv
// Three-row barcode scan sequencer: run-length encodes fixed scan rows of the
// pixel stream, buffers the row-1 run widths and issues a per-frame pass/fail verdict.
module barcode_scan_ctrl #(
  parameter logic [9:0] ROW1      = 10'd4,
  parameter logic [9:0] ROW2      = 10'd9,
  parameter logic [9:0] ROW3      = 10'd14,
  parameter int         MIN_BARS  = 4,
  parameter int         MAX_BARS  = 63,
  parameter int         MIN_QUIET = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] y_in,
  input  logic       in_de,
  input  logic       in_vs,
  input  logic       in_data,
  output logic       scan_en,
  output logic       result_valid,
  output logic [5:0] bar_cnt,
  input  logic [5:0] rd_addr,
  output logic [9:0] rd_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_ROW_END = 3'd3;
  localparam logic [2:0] S_JUDGE   = 3'd4;

  localparam logic [9:0] QUIET_W = 10'(MIN_QUIET);
  localparam logic [6:0] BARS_LO = 7'(MIN_BARS);
  localparam logic [6:0] BARS_HI = 7'(MAX_BARS);

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'd127) ? v : v + 7'd1;
  endfunction

  logic [2:0]       r_state;
  logic [1:0]       r_k;
  logic             r_vs_d;
  logic             r_cur;
  logic [9:0]       r_len;
  logic [6:0]       r_blk;
  logic             r_have_first;
  logic             r_first_cur;
  logic [9:0]       r_first_len;
  logic             r_last_cur;
  logic [9:0]       r_last_len;
  logic [6:0]       r_wr_idx;
  logic             r_ovf;
  logic [2:0]       r_row_ok;
  logic [2:0][6:0]  r_cnt;
  logic [9:0]       r_mem [0:63];

  logic       w_vs_rise;
  logic       w_abort;
  logic [9:0] w_row_y;
  logic       w_start;
  logic       w_commit;
  logic       w_buf_we;
  logic       w_row_ok;
  logic       w_pass;

  // r_k holds the scan row index as 0..2 for rows 1..3
  assign w_vs_rise = in_vs & ~r_vs_d;
  assign w_abort   = w_vs_rise && (r_state != S_IDLE);
  assign w_row_y   = (r_k == 2'd0) ? ROW1 : (r_k == 2'd1) ? ROW2 : ROW3;
  assign w_start   = (r_state == S_WAIT) && in_de && (y_in == w_row_y) && !w_abort;
  assign w_commit  = (r_state == S_RUN) && (!in_de || (in_data != r_cur));
  assign w_buf_we  = w_commit && (r_k == 2'd0) && !r_wr_idx[6];

  assign w_row_ok = !r_first_cur && (r_first_len >= QUIET_W) &&
                    !r_last_cur  && (r_last_len  >= QUIET_W) &&
                    (r_blk >= BARS_LO) && (r_blk <= BARS_HI) &&
                    !((r_k == 2'd0) && r_ovf);

  assign w_pass = (&r_row_ok) && (r_cnt[0] == r_cnt[1]) && (r_cnt[1] == r_cnt[2]);

  // Sequencer and verdict outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_k          <= 2'd0;
      r_vs_d       <= 1'b0;
      r_row_ok     <= '0;
      r_cnt        <= '0;
      scan_en      <= 1'b0;
      result_valid <= 1'b0;
      bar_cnt      <= 6'd0;
    end else begin
      r_vs_d       <= in_vs;
      result_valid <= 1'b0;
      if (w_abort) begin
        r_state <= S_WAIT;
        r_k     <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_vs_rise) begin
              r_state <= S_WAIT;
              r_k     <= 2'd0;
            end
          end
          S_WAIT: begin
            if (w_start) r_state <= S_RUN;
          end
          S_RUN: begin
            if (!in_de) r_state <= S_ROW_END;
          end
          S_ROW_END: begin
            r_row_ok[r_k] <= w_row_ok;
            r_cnt[r_k]    <= r_blk;
            if (r_k == 2'd2) begin
              r_state <= S_JUDGE;
            end else begin
              r_k     <= r_k + 2'd1;
              r_state <= S_WAIT;
            end
          end
          S_JUDGE: begin
            scan_en      <= w_pass;
            bar_cnt      <= w_pass ? r_cnt[0][5:0] : 6'd0;
            result_valid <= 1'b1;
            r_state      <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Run-length counters; the commit on the in_de=0 cycle closes the row's last run
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur        <= 1'b0;
      r_len        <= 10'd0;
      r_blk        <= 7'd0;
      r_have_first <= 1'b0;
      r_first_cur  <= 1'b0;
      r_first_len  <= 10'd0;
      r_last_cur   <= 1'b0;
      r_last_len   <= 10'd0;
      r_wr_idx     <= 7'd0;
      r_ovf        <= 1'b0;
    end else if (w_start) begin
      r_cur        <= in_data;
      r_len        <= 10'd1;
      r_blk        <= 7'd0;
      r_have_first <= 1'b0;
      if (r_k == 2'd0) begin
        r_wr_idx <= 7'd0;
        r_ovf    <= 1'b0;
      end
    end else if (w_commit) begin
      if (r_cur) r_blk <= sat_inc7(r_blk);
      if (!r_have_first) begin
        r_have_first <= 1'b1;
        r_first_cur  <= r_cur;
        r_first_len  <= r_len;
      end
      r_last_cur <= r_cur;
      r_last_len <= r_len;
      if (r_k == 2'd0) begin
        if (r_wr_idx[6]) r_ovf <= 1'b1;
        else             r_wr_idx <= r_wr_idx + 7'd1;
      end
      r_cur <= in_data;
      r_len <= 10'd1;
    end else if (r_state == S_RUN) begin
      r_len <= sat_inc10(r_len);
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) r_mem[r_wr_idx[5:0]] <= r_len;
  end

  // Read-before-write: a same-address write this cycle is not yet visible
  always_ff @(posedge clk) begin
    if (rst) rd_data <= 10'd0;
    else     rd_data <= r_mem[rd_addr];
  end

endmodule
